parking_top: RTL and testbench



---
 rtl/parking_top.sv | 217 +++++++++++++++++++++
 tb/tb_parking_top.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_top.sv
// ---------------------------------------------------------------------------
// parking_top -- car-park occupancy controller with two pools (general and
// university) and a built-in time-of-day clock.
//
// The pools share TOTAL_CAP spaces. The general-pool capacity G follows the
// hour of day, and the university pool gets the remainder. Each pool is one
// parking_pool instance; the pools are built with a generate loop over
// NUM_POOLS (0 = general, 1 = university).
//
// Ports:
//   car_entered, is_uni_car_entered   entry request and the pool it targets
//   car_exited,  is_uni_car_exited    exit request and the pool it targets
//   clk                               rising-edge clock
//   enable                            gates entry/exit processing
//   enable_cnt                        gates the time-of-day counter
//   reset_cnt                         asynchronous active-high reset
//   h, m, d                           hour (0..23), minute (0..59), day (wraps at 128)
//   parked_cars, uni_parked_cars      pool occupancy
//   vacated_space, uni_vacated_space  free spaces (saturate at 0)
//   is_vacated_space, uni_is_vacated_space   pool has at least one free space
//   no_car_error                      registered pulse: exit from an empty pool
//   capacity_error, uni_capacity_error     occupancy above current capacity
// ---------------------------------------------------------------------------
package parking_pkg;
  localparam int CNT_W     = 10;
  localparam int NUM_POOLS = 2;
  localparam int POOL_GEN  = 0;
  localparam int POOL_UNI  = 1;

  typedef struct packed {
    logic ent;
    logic ext;
  } pool_req_t;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] vac;
    logic             has_vac;
    logic             over;
    logic             underflow;
  } pool_rsp_t;
endpackage

// ---------------------------------------------------------------------------
// parking_pool -- occupancy counter for a single pool.
//   req.ent / req.ext are already qualified by enable and pool selection.
//   cap is the pool's current capacity.
//   rsp carries the count, saturating free space, availability, over-capacity
//   and an underflow indicator (exit requested while the pool is empty).
// ---------------------------------------------------------------------------
module parking_pool
  import parking_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  pool_req_t        req,
  input  logic [CNT_W-1:0] cap,
  output pool_rsp_t        rsp
);
  logic [CNT_W-1:0] count;
  logic             room;
  logic             inc;
  logic             dec;

  // Entry and exit are both judged against the pre-edge count, so a
  // simultaneous entry/exit on an empty pool still admits the car.
  always_comb begin
    room = (count < cap);
    inc  = req.ent && room;
    dec  = req.ext && (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (enable)
      count <= count + CNT_W'(inc) - CNT_W'(dec);
  end

  // Capacity can shrink below the count when the hour changes. Cars are
  // never evicted, so free space saturates at zero and 'over' flags it.
  always_comb begin
    rsp           = '0;
    rsp.count     = count;
    rsp.vac       = room ? (cap - count) : '0;
    rsp.has_vac   = room;
    rsp.over      = (count > cap);
    rsp.underflow = req.ext && (count == '0);
  end
endmodule

// ---------------------------------------------------------------------------
// parking_top
// ---------------------------------------------------------------------------
module parking_top
  import parking_pkg::*;
#(
  parameter int TOTAL_CAP = 700,
  parameter int DAY_CAP   = 200,
  parameter int NIGHT_CAP = 500,
  parameter int STEP      = 50
) (
  input  logic        car_entered,
  input  logic        is_uni_car_entered,
  input  logic        car_exited,
  input  logic        is_uni_car_exited,
  input  logic        clk,
  input  logic        enable,
  input  logic        enable_cnt,
  input  logic        reset_cnt,
  output logic [4:0]  h,
  output logic [6:0]  m,
  output logic [6:0]  d,
  output logic [9:0]  uni_parked_cars,
  output logic [9:0]  parked_cars,
  output logic [9:0]  uni_vacated_space,
  output logic [9:0]  vacated_space,
  output logic        uni_is_vacated_space,
  output logic        is_vacated_space,
  output logic        no_car_error,
  output logic        uni_capacity_error,
  output logic        capacity_error
);
  // ---------------- time of day ----------------
  logic [4:0] hour_q;
  logic [6:0] min_q;
  logic [6:0] day_q;

  always_ff @(posedge clk or posedge reset_cnt) begin
    if (reset_cnt) begin
      hour_q <= '0;
      min_q  <= '0;
      day_q  <= '0;
    end else if (enable_cnt) begin
      if (min_q == 7'd59) begin
        min_q <= '0;
        if (hour_q == 5'd23) begin
          hour_q <= '0;
          day_q  <= day_q + 7'd1;  // 7-bit, wraps 127 -> 0
        end else begin
          hour_q <= hour_q + 5'd1;
        end
      end else begin
        min_q <= min_q + 7'd1;
      end
    end
  end

  // ---------------- capacity schedule ----------------
  // General capacity ramps from DAY_CAP by STEP per hour through 13..15,
  // then jumps to NIGHT_CAP at 16:00. University gets the remainder.
  function automatic logic [CNT_W-1:0] gen_cap(input logic [4:0] hr);
    logic [CNT_W-1:0] c;
    if (hr >= 5'd8 && hr <= 5'd12)
      c = CNT_W'(DAY_CAP);
    else if (hr >= 5'd13 && hr <= 5'd15)
      c = CNT_W'(DAY_CAP + STEP * (int'(hr) - 12));
    else
      c = CNT_W'(NIGHT_CAP);
    return c;
  endfunction

  logic [NUM_POOLS-1:0][CNT_W-1:0] cap;

  always_comb begin
    cap           = '0;
    cap[POOL_GEN] = gen_cap(hour_q);
    cap[POOL_UNI] = CNT_W'(TOTAL_CAP) - cap[POOL_GEN];
  end

  // ---------------- pools ----------------
  pool_req_t [NUM_POOLS-1:0] req;
  pool_rsp_t [NUM_POOLS-1:0] rsp;
  logic      [NUM_POOLS-1:0] underflow;

  for (genvar i = 0; i < NUM_POOLS; i++) begin : g_pool
    localparam logic IS_UNI = (i == POOL_UNI);

    always_comb begin
      req[i].ent = enable && car_entered && (is_uni_car_entered == IS_UNI);
      req[i].ext = enable && car_exited  && (is_uni_car_exited  == IS_UNI);
    end

    parking_pool u_pool (
      .clk    (clk),
      .rst    (reset_cnt),
      .enable (enable),
      .req    (req[i]),
      .cap    (cap[i]),
      .rsp    (rsp[i])
    );

    assign underflow[i] = rsp[i].underflow;
  end

  // Rewritten every edge, so it is a one-cycle pulse per failing exit.
  always_ff @(posedge clk or posedge reset_cnt) begin
    if (reset_cnt)
      no_car_error <= 1'b0;
    else
      no_car_error <= |underflow;
  end

  // ---------------- outputs ----------------
  assign h                    = hour_q;
  assign m                    = min_q;
  assign d                    = day_q;
  assign parked_cars          = rsp[POOL_GEN].count;
  assign uni_parked_cars      = rsp[POOL_UNI].count;
  assign vacated_space        = rsp[POOL_GEN].vac;
  assign uni_vacated_space    = rsp[POOL_UNI].vac;
  assign is_vacated_space     = rsp[POOL_GEN].has_vac;
  assign uni_is_vacated_space = rsp[POOL_UNI].has_vac;
  assign capacity_error       = rsp[POOL_GEN].over;
  assign uni_capacity_error   = rsp[POOL_UNI].over;
endmodule

// File: tb/tb_parking_top.sv
// ---------------------------------------------------------------------------
// tb_parking_top -- directed self-checking bench for parking_top.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_parking_top;
  logic       clk = 1'b0;
  logic       reset_cnt;
  logic       car_entered, is_uni_car_entered;
  logic       car_exited, is_uni_car_exited;
  logic       enable, enable_cnt;
  logic [4:0] h;
  logic [6:0] m, d;
  logic [9:0] uni_parked_cars, parked_cars, uni_vacated_space, vacated_space;
  logic       uni_is_vacated_space, is_vacated_space, no_car_error;
  logic       uni_capacity_error, capacity_error;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  parking_top dut (
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .clk                  (clk),
    .enable               (enable),
    .enable_cnt           (enable_cnt),
    .reset_cnt            (reset_cnt),
    .h                    (h),
    .m                    (m),
    .d                    (d),
    .uni_parked_cars      (uni_parked_cars),
    .parked_cars          (parked_cars),
    .uni_vacated_space    (uni_vacated_space),
    .vacated_space        (vacated_space),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .no_car_error         (no_car_error),
    .uni_capacity_error   (uni_capacity_error),
    .capacity_error       (capacity_error)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, ".h"}, h, 0);
    chk({pfx, ".m"}, m, 0);
    chk({pfx, ".d"}, d, 0);
    chk({pfx, ".parked"}, parked_cars, 0);
    chk({pfx, ".uni_parked"}, uni_parked_cars, 0);
    chk({pfx, ".vac"}, vacated_space, 500);
    chk({pfx, ".uni_vac"}, uni_vacated_space, 200);
    chk({pfx, ".is_vac"}, is_vacated_space, 1);
    chk({pfx, ".uni_is_vac"}, uni_is_vacated_space, 1);
    chk({pfx, ".no_car"}, no_car_error, 0);
    chk({pfx, ".cap_err"}, capacity_error, 0);
    chk({pfx, ".uni_cap_err"}, uni_capacity_error, 0);
  endtask

  initial begin
    reset_cnt = 1'b1;
    car_entered = 0; is_uni_car_entered = 0;
    car_exited = 0;  is_uni_car_exited = 0;
    enable = 0; enable_cnt = 0;
    #12;
    chk_reset_vals("rst");
    @(posedge clk); #1;
    reset_cnt = 1'b0;

    // 480 minutes -> 08:00
    enable_cnt = 1;
    cyc(480);
    enable_cnt = 0;
    chk("t8.h", h, 8);
    chk("t8.m", m, 0);
    chk("t8.vac", vacated_space, 200);
    chk("t8.uni_vac", uni_vacated_space, 500);

    // general pool fill, 201st entry refused
    enable = 1;
    car_entered = 1; is_uni_car_entered = 0;
    cyc(201);
    chk("gfill.parked", parked_cars, 200);
    chk("gfill.vac", vacated_space, 0);
    chk("gfill.is_vac", is_vacated_space, 0);
    chk("gfill.cap_err", capacity_error, 0);

    // university pool fill, 501st entry refused
    is_uni_car_entered = 1;
    cyc(501);
    car_entered = 0;
    chk("ufill.uni_parked", uni_parked_cars, 500);
    chk("ufill.uni_is_vac", uni_is_vacated_space, 0);
    chk("ufill.uni_vac", uni_vacated_space, 0);
    chk("ufill.parked", parked_cars, 200);

    // asynchronous reset between edges
    #2;
    reset_cnt = 1'b1;
    #1;
    chk_reset_vals("arst");
    @(posedge clk); #1;
    reset_cnt = 1'b0;

    // exit from empty university pool
    car_exited = 1; is_uni_car_exited = 1;
    cyc();
    chk("empty.no_car", no_car_error, 1);
    chk("empty.uni_parked", uni_parked_cars, 0);
    car_exited = 0;
    cyc();
    chk("empty.no_car_clr", no_car_error, 0);

    // to 08:00, park 400 uni, then to 16:00
    enable_cnt = 1;
    cyc(480);
    enable_cnt = 0;
    car_entered = 1; is_uni_car_entered = 1;
    cyc(400);
    car_entered = 0;
    chk("u400.uni_parked", uni_parked_cars, 400);
    chk("u400.uni_cap_err", uni_capacity_error, 0);
    chk("u400.uni_vac", uni_vacated_space, 100);
    enable_cnt = 1;
    cyc(480);
    enable_cnt = 0;
    chk("t16.h", h, 16);
    chk("t16.uni_cap_err", uni_capacity_error, 1);
    chk("t16.uni_vac", uni_vacated_space, 0);
    chk("t16.vac", vacated_space, 500);

    // entry to over-capacity pool refused
    car_entered = 1; is_uni_car_entered = 1;
    cyc();
    car_entered = 0;
    chk("over.uni_parked", uni_parked_cars, 400);

    // drain to capacity
    car_exited = 1; is_uni_car_exited = 1;
    cyc(199);
    chk("drain199.uni_parked", uni_parked_cars, 201);
    chk("drain199.uni_cap_err", uni_capacity_error, 1);
    cyc();
    car_exited = 0;
    chk("drain200.uni_parked", uni_parked_cars, 200);
    chk("drain200.uni_cap_err", uni_capacity_error, 0);
    chk("drain200.uni_is_vac", uni_is_vacated_space, 0);
    chk("drain200.no_car", no_car_error, 0);

    // simultaneous entry/exit on empty general pool
    car_entered = 1; is_uni_car_entered = 0;
    car_exited = 1;  is_uni_car_exited = 0;
    cyc();
    chk("simul0.parked", parked_cars, 1);
    chk("simul0.no_car", no_car_error, 1);
    car_exited = 0;
    cyc(9);
    chk("g10.parked", parked_cars, 10);
    chk("g10.no_car", no_car_error, 0);
    car_exited = 1;
    cyc();
    chk("simul10.parked", parked_cars, 10);
    chk("simul10.vac", vacated_space, 490);

    // enable=0 freezes counts
    enable = 0;
    car_exited = 0;
    cyc(3);
    car_entered = 0;
    chk("frz.parked", parked_cars, 10);
    chk("frz.uni_parked", uni_parked_cars, 200);

    // clock through midnight and into the next hour
    enable_cnt = 1;
    cyc(480);
    chk("mid.h", h, 0);
    chk("mid.m", m, 0);
    chk("mid.d", d, 1);
    chk("mid.uni_vac", uni_vacated_space, 0);
    chk("mid.uni_cap_err", uni_capacity_error, 0);
    cyc(75);
    enable_cnt = 0;
    chk("t0115.h", h, 1);
    chk("t0115.m", m, 15);
    cyc(5);
    chk("hold.m", m, 15);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
